// File: rtl/cp0_reg.sv
// cp0_reg: MIPS coprocessor-0 register file with exception recording.
// Define CP0_TIMER_EN to enable the free-running Count and the Count/Compare timer interrupt.
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] STATUS_RST   = 32'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  // Software-writable Cause bits: IV, WP and the two software interrupt pending bits.
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] status_wr, cause_wr, epc_wr;
  logic [31:0] count_nxt, status_nxt, cause_nxt, epc_nxt;
  logic        exc_hit;
  logic [4:0]  exc_code;
  logic [31:0] rdata;

  assign wr_count   = we_i && (waddr_i == REG_COUNT);
  assign wr_compare = we_i && (waddr_i == REG_COMPARE);
  assign wr_status  = we_i && (waddr_i == REG_STATUS);
  assign wr_cause   = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc     = we_i && (waddr_i == REG_EPC);

  assign config_o = CONFIG_VALUE;
  assign prid_o   = PRID_VALUE;

  assign status_wr = wr_status ? data_i : status_o;
  assign epc_wr    = wr_epc ? data_i : epc_o;

`ifdef CP0_TIMER_EN
  assign count_nxt = wr_count ? data_i : count_o + 32'd1;
`else
  assign count_nxt = wr_count ? data_i : count_o;
`endif

  // Write-merged Cause; hardware interrupt lines always own IP7..IP2.
  always_comb begin
    cause_wr = cause_o;
    if (wr_cause) cause_wr = (cause_o & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
    cause_wr[15:10] = int_i;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    exc_hit    = 1'b0;
    exc_code   = 5'd0;
    status_nxt = status_wr;
    cause_nxt  = cause_wr;
    epc_nxt    = epc_wr;
    case (excepttype_i)
      EXC_INT:  begin exc_hit = 1'b1; exc_code = 5'd0;  end
      EXC_SYS:  begin exc_hit = 1'b1; exc_code = 5'd8;  end
      EXC_RI:   begin exc_hit = 1'b1; exc_code = 5'd10; end
      EXC_OV:   begin exc_hit = 1'b1; exc_code = 5'd12; end
      EXC_TRAP: begin exc_hit = 1'b1; exc_code = 5'd13; end
      EXC_ERET: status_nxt[1] = 1'b0;
      default: ;
    endcase
    // Exception state overrides any same-cycle mtc0; EPC/BD judged on the committed EXL.
    if (exc_hit) begin
      if (!status_o[1]) begin
        epc_nxt       = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        cause_nxt[31] = is_in_delayslot_i;
      end
      cause_nxt[6:2] = exc_code;
      status_nxt[1]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_o   <= '0;
      compare_o <= '0;
      status_o  <= STATUS_RST;
      cause_o   <= '0;
      epc_o     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      count_o  <= count_nxt;
      status_o <= status_nxt;
      cause_o  <= cause_nxt;
      epc_o    <= epc_nxt;
      if (wr_compare) compare_o <= data_i;
    end
  end

`ifdef CP0_TIMER_EN
  // Sticky until software rewrites Compare; that write beats a same-cycle match.
  always_ff @(posedge clk) begin
    if (rst)                                          timer_int_o <= 1'b0;
    else if (wr_compare)                              timer_int_o <= 1'b0;
    else if ((compare_o != '0) && (count_o == compare_o)) timer_int_o <= 1'b1;
  end
`else
  assign timer_int_o = 1'b0;
`endif

  // A write to the register being read is forwarded, so mfc0 sees the merged value.
  always_comb begin
    rdata = '0;
    case (raddr_i)
      REG_COUNT:   rdata = wr_count ? data_i : count_o;
      REG_COMPARE: rdata = wr_compare ? data_i : compare_o;
      REG_STATUS:  rdata = status_wr;
      REG_CAUSE:   rdata = wr_cause ? cause_wr : cause_o;
      REG_EPC:     rdata = epc_wr;
      REG_PRID:    rdata = PRID_VALUE;
      REG_CONFIG:  rdata = CONFIG_VALUE;
      default:     rdata = '0;
    endcase
  end

  assign data_o = rst ? 32'd0 : rdata;

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed scoreboard bench for cp0_reg; expectations adapt to CP0_TIMER_EN.
`timescale 1ns/1ps
module tb_cp0_reg;
`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i, current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
    .data_i(data_i), .int_i(int_i), .excepttype_i(excepttype_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
    .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  typedef enum {S_DATA, S_COUNT, S_COMPARE, S_STATUS, S_CAUSE, S_EPC, S_CONFIG, S_PRID, S_TIMER} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      S_DATA:    return data_o;
      S_COUNT:   return count_o;
      S_COMPARE: return compare_o;
      S_STATUS:  return status_o;
      S_CAUSE:   return cause_o;
      S_EPC:     return epc_o;
      S_CONFIG:  return config_o;
      S_PRID:    return prid_o;
      S_TIMER:   return {31'd0, timer_int_o};
      default:   return 32'd0;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance one clock edge, then compare everything queued for that edge.
  task automatic step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Compare combinational expectations without clocking.
  task automatic peek();
    #1;
    check_all();
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] value);
    we_i    = 1'b1;
    waddr_i = addr;
    data_i  = value;
  endtask

  task automatic exc(input logic [31:0] code, input logic [31:0] addr, input logic ds);
    excepttype_i        = code;
    current_inst_addr_i = addr;
    is_in_delayslot_i   = ds;
  endtask

  task automatic idle();
    we_i         = 1'b0;
    excepttype_i = 32'd0;
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = '0; raddr_i = 5'd15; data_i = '0; int_i = '0;
    excepttype_i = '0; current_inst_addr_i = '0; is_in_delayslot_i = 1'b0;

    // Reset behaviour
    expect_val("data_during_reset", S_DATA, 32'h0);
    peek();
    step(); step();
    expect_val("rst_count",   S_COUNT,   32'h0);
    expect_val("rst_compare", S_COMPARE, 32'h0);
    expect_val("rst_status",  S_STATUS,  32'h10000000);
    expect_val("rst_cause",   S_CAUSE,   32'h0);
    expect_val("rst_epc",     S_EPC,     32'h0);
    expect_val("rst_config",  S_CONFIG,  32'h00008000);
    expect_val("rst_prid",    S_PRID,    32'h004c0102);
    expect_val("rst_timer",   S_TIMER,   32'h0);
    peek();

    rst = 1'b0;
    repeat (5) step();
    expect_val("idle_count",  S_COUNT,  TIMER ? 32'd5 : 32'd0);
    expect_val("idle_status", S_STATUS, 32'h10000000);
    expect_val("read_prid",   S_DATA,   32'h004c0102);
    peek();
    raddr_i = 5'd3;
    expect_val("read_unlisted", S_DATA, 32'h0);
    peek();

    // Cause merge: only IV/WP/IP9..8 writable, IP7..2 follow int_i
    mtc0(5'd13, 32'hFFFFFFFF); int_i = 6'b000101; raddr_i = 5'd13;
    expect_val("cause_fwd", S_DATA, 32'h00C01700);
    peek();
    expect_val("cause_merge", S_CAUSE, 32'h00C01700);
    step();
    idle(); int_i = 6'b000000;
    expect_val("cause_ip_follow", S_CAUSE, 32'h00C00300);
    step();

    // Timer: Count load, Compare match, sticky, clear
    mtc0(5'd9, 32'h10);
    expect_val("count_load", S_COUNT, 32'h10);
    step();
    mtc0(5'd11, 32'h20);
    expect_val("compare_load", S_COMPARE, 32'h20);
    expect_val("count_after", S_COUNT, TIMER ? 32'h11 : 32'h10);
    step();
    idle();
    repeat (15) step();
    expect_val("count_at_match", S_COUNT, TIMER ? 32'h20 : 32'h10);
    expect_val("timer_pre",      S_TIMER, 32'h0);
    peek();
    expect_val("timer_set", S_TIMER, {31'd0, TIMER});
    step();
    repeat (3) step();
    expect_val("timer_sticky", S_TIMER, {31'd0, TIMER});
    peek();
    mtc0(5'd11, 32'h40);
    expect_val("timer_clear", S_TIMER,   32'h0);
    expect_val("compare_40",  S_COMPARE, 32'h40);
    step();
    idle();

    // Count wrap
    mtc0(5'd9, 32'hFFFFFFFF);
    expect_val("count_max", S_COUNT, 32'hFFFFFFFF);
    step();
    idle();
    expect_val("count_wrap", S_COUNT, TIMER ? 32'h0 : 32'hFFFFFFFF);
    step();

    // Compare write beats a same-cycle match
    mtc0(5'd9, 32'h3E);
    expect_val("count_3e", S_COUNT, 32'h3E);
    step();
    idle();
    step(); step();
    expect_val("count_40", S_COUNT, TIMER ? 32'h40 : 32'h3E);
    expect_val("timer_before_race", S_TIMER, 32'h0);
    peek();
    mtc0(5'd11, 32'h40);
    expect_val("timer_clear_wins", S_TIMER, 32'h0);
    step();
    idle();
    expect_val("timer_still_clear", S_TIMER, 32'h0);
    step();

    // Exceptions
    exc(32'h08, 32'h100, 1'b0);
    expect_val("sys_epc",    S_EPC,    32'h100);
    expect_val("sys_cause",  S_CAUSE,  32'h00C00320);
    expect_val("sys_status", S_STATUS, 32'h10000002);
    step();
    exc(32'h0e, 32'h0, 1'b0);
    expect_val("eret_status", S_STATUS, 32'h10000000);
    expect_val("eret_epc",    S_EPC,    32'h100);
    step();
    exc(32'h08, 32'h204, 1'b1);
    expect_val("ds_epc",    S_EPC,    32'h200);
    expect_val("ds_cause",  S_CAUSE,  32'h80C00320);
    expect_val("ds_status", S_STATUS, 32'h10000002);
    step();
    exc(32'h0c, 32'h300, 1'b0);
    expect_val("exl_epc_hold", S_EPC,   32'h200);
    expect_val("exl_cause",    S_CAUSE, 32'h80C00330);
    step();
    exc(32'h0e, 32'h0, 1'b0);
    expect_val("eret2_status", S_STATUS, 32'h10000000);
    expect_val("eret2_epc",    S_EPC,    32'h200);
    step();
    exc(32'h05, 32'h500, 1'b1);
    expect_val("unk_cause",  S_CAUSE,  32'h80C00330);
    expect_val("unk_status", S_STATUS, 32'h10000000);
    expect_val("unk_epc",    S_EPC,    32'h200);
    step();
    exc(32'h01, 32'h400, 1'b0);
    expect_val("int_epc",   S_EPC,   32'h400);
    expect_val("int_cause", S_CAUSE, 32'h00C00300);
    step();
    exc(32'h0a, 32'h600, 1'b1);
    expect_val("ri_epc_hold", S_EPC,   32'h400);
    expect_val("ri_cause",    S_CAUSE, 32'h00C00328);
    step();
    exc(32'h0e, 32'h0, 1'b0);
    step();
    idle();

    // Full-width writes, forwarding, read-only registers
    mtc0(5'd12, 32'h0000FF01); raddr_i = 5'd12;
    expect_val("status_fwd", S_DATA, 32'h0000FF01);
    peek();
    expect_val("status_wr", S_STATUS, 32'h0000FF01);
    step();
    mtc0(5'd14, 32'hDEADBEE0); raddr_i = 5'd14;
    expect_val("epc_fwd", S_DATA, 32'hDEADBEE0);
    peek();
    expect_val("epc_wr", S_EPC, 32'hDEADBEE0);
    step();
    mtc0(5'd15, 32'h0); raddr_i = 5'd15;
    expect_val("prid_ro_fwd", S_DATA, 32'h004c0102);
    peek();
    mtc0(5'd16, 32'h0); raddr_i = 5'd16;
    expect_val("config_ro_fwd", S_DATA, 32'h00008000);
    peek();
    step();
    expect_val("prid_ro", S_PRID, 32'h004c0102);
    peek();

    // Trap with conflicting mtc0 to Status: exception bits win
    mtc0(5'd12, 32'h0); exc(32'h0d, 32'h700, 1'b0);
    expect_val("trap_epc",    S_EPC,    32'h700);
    expect_val("trap_cause",  S_CAUSE,  32'h00C00334);
    expect_val("trap_status", S_STATUS, 32'h00000002);
    step();

    // Reset mid-operation overrides write and exception
    rst = 1'b1; mtc0(5'd12, 32'hFFFFFFFF); exc(32'h08, 32'h800, 1'b1); raddr_i = 5'd12;
    expect_val("data_mid_reset", S_DATA, 32'h0);
    peek();
    expect_val("mrst_status",  S_STATUS,  32'h10000000);
    expect_val("mrst_cause",   S_CAUSE,   32'h0);
    expect_val("mrst_epc",     S_EPC,     32'h0);
    expect_val("mrst_count",   S_COUNT,   32'h0);
    expect_val("mrst_compare", S_COMPARE, 32'h0);
    step();
    rst = 1'b0; idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
